// File: rtl/ahb_slave_mem.sv
// ahb_slave_mem: AHB word memory responder with programmable wait states.
// Define AHB_SLV_ERR_RESP_EN for the ERROR response on bad size/alignment/range.
module ahb_slave_mem #(
    parameter int ADDR_W      = 4,
    parameter int WAIT_STATES = 1
) (
    input  logic        hclk,
    input  logic        hreset,
    input  logic        hsel,
    input  logic [31:0] haddr,
    input  logic [1:0]  htrans,
    input  logic        hwrite,
    input  logic [2:0]  hsize,
    input  logic [31:0] hwdata,
    input  logic        hready,
    output logic        hreadyout,
    output logic [1:0]  hresp,
    output logic [31:0] hrdata
);
    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        DATA
`ifdef AHB_SLV_ERR_RESP_EN
        , ERR1,
        ERR2
`endif
    } state_t;
    localparam logic [2:0] WS = 3'(WAIT_STATES);
    logic [31:0]       mem [2**ADDR_W];
    state_t            state, nxt, acc_st;
    logic [2:0]        cnt;
    logic [ADDR_W-1:0] idx_q;
    logic [1:0]        lane_q;
    logic [2:0]        size_q;
    logic              wr_q;
    logic              accept, load;
    logic [3:0]        be;
    logic [31:0]       wmerged;
    assign accept = hsel && hready && htrans[1];
`ifdef AHB_SLV_ERR_RESP_EN
    logic err;
    assign err = hsize > 3'd2 || (hsize == 3'd1 && haddr[0]) ||
                 (hsize == 3'd2 && haddr[1:0] != 2'b00) || haddr[31:ADDR_W+2] != '0;
    assign acc_st = err ? ERR1 : (WAIT_STATES > 0 ? WAIT : DATA);
`else
    logic unused_hi;
    assign unused_hi = ^haddr[31:ADDR_W+2];
    assign acc_st = WAIT_STATES > 0 ? WAIT : DATA;
`endif
    always_comb begin
        nxt  = IDLE;
        load = 1'b0;
        case (state)
            WAIT: nxt = cnt == 3'd1 ? DATA : WAIT;
`ifdef AHB_SLV_ERR_RESP_EN
            ERR1: nxt = ERR2;
`endif
            default: begin
                load = accept;
                nxt  = accept ? acc_st : IDLE;
            end
        endcase
    end
    // Out-of-size hsize falls through to word lanes; misaligned lanes align down.
    assign be = size_q == 3'd0 ? 4'b0001 << lane_q :
                size_q == 3'd1 ? (lane_q[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    always_comb begin
        wmerged = mem[idx_q];
        for (int i = 0; i < 4; i++)
            if (be[i]) wmerged[8*i +: 8] = hwdata[8*i +: 8];
    end
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            state     <= IDLE;
            hreadyout <= 1'b1;
            cnt       <= '0;
            idx_q     <= '0;
            lane_q    <= '0;
            size_q    <= '0;
            wr_q      <= 1'b0;
            for (int i = 0; i < 2**ADDR_W; i++) mem[i] <= '0;
        end else begin
            state <= nxt;
`ifdef AHB_SLV_ERR_RESP_EN
            hreadyout <= nxt != WAIT && nxt != ERR1;
`else
            hreadyout <= nxt != WAIT;
`endif
            if (state == DATA && wr_q) mem[idx_q] <= wmerged;
            if (load) begin
                idx_q  <= haddr[ADDR_W+1:2];
                lane_q <= haddr[1:0];
                size_q <= hsize;
                wr_q   <= hwrite;
                cnt    <= WS;
            end else if (state == WAIT) begin
                cnt <= cnt - 3'd1;
            end
        end
    end
`ifdef AHB_SLV_ERR_RESP_EN
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) hresp <= 2'b00;
        else        hresp <= (nxt == ERR1 || nxt == ERR2) ? 2'b01 : 2'b00;
    end
`else
    assign hresp = 2'b00;
`endif
    // Reads see the memory after any preceding write has committed.
    assign hrdata = (state == DATA && !wr_q) ? mem[idx_q] : '0;
endmodule

// File: doc/ahb_slave_mem.md
Name: ahb_slave_mem

Overview:
- AHB responder: a word-organised register memory that answers transfers issued by the master interface.
- Sits on the slave side of the AHB fabric, selected by the decoder through hsel.
- Provides configurable wait states and a two-cycle ERROR response, so the master side can be exercised against OKAY, stalled and failing transfers.

Parameters:
- ADDR_W, 4: word-address bits. Memory depth is 2^ADDR_W 32-bit words; the valid byte range is 0 .. 4*2^ADDR_W-1.
- WAIT_STATES, 1: number of hreadyout-low cycles inserted in each OKAY data phase (0..7).

Ports:
- hclk  in  1  bus clock; all logic on rising edge.
- hreset  in  1  reset, asynchronous, active-high.
- hsel  in  1  slave select from decoder.
- haddr  in  32  byte address (address phase).
- htrans  in  2  transfer type: 00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
- hwrite  in  1  1 = write, 0 = read (address phase).
- hsize  in  3  000 byte, 001 halfword, 010 word.
- hwdata  in  32  write data (data phase).
- hready  in  1  bus-level ready; an address phase is only sampled when it is 1.
- hreadyout  out  1  this slave's ready.
- hresp  out  2  00 OKAY, 01 ERROR.
- hrdata  out  32  read data, valid when hreadyout=1 in a read data phase.

Behaviour:
- Reset (asynchronous, any time, including mid-transfer):
  - hreadyout=1, hresp=00, hrdata=0.
  - All memory words cleared to 0.
  - FSM to IDLE; any pending transfer is dropped and no write commits.
- Accept condition: hsel & hready & htrans[1]. On acceptance, latch haddr, hwrite and hsize.
- IDLE/BUSY transfers, or hsel=0: no data phase; hreadyout=1, hresp=00.
- Error conditions, checked at acceptance:
  - hsize>2;
  - misalignment (halfword with haddr[0]=1, word with haddr[1:0]!=0);
  - haddr[31:ADDR_W+2]!=0.
- FSM states: IDLE, WAIT, DATA, ERR1, ERR2.
  - IDLE: on an accepted error transfer -> ERR1. On an accepted OKAY transfer -> WAIT (wait counter loaded with WAIT_STATES) if WAIT_STATES>0, else -> DATA.
  - WAIT: hreadyout=0, hresp=00. Counter decrements each cycle; on reaching 1 -> DATA.
  - DATA: hreadyout=1, hresp=00. This is the final data-phase cycle.
    - Write: commit hwdata byte lanes selected by latched haddr[1:0]/hsize to mem[haddr[ADDR_W+1:2]]. Byte at lane haddr[1:0]; halfword at lanes {haddr[1],0}+1:0; word all lanes.
    - Read: hrdata = full stored word (master extracts lanes).
    - Pipelining: a new transfer may be accepted in this same cycle and goes to WAIT/DATA/ERR1 as from IDLE; otherwise -> IDLE.
  - ERR1: hreadyout=0, hresp=01; no memory access -> ERR2.
  - ERR2: hreadyout=1, hresp=01.
    - A new accept in this cycle is honoured as in DATA; otherwise -> IDLE.
    - If the master drives htrans=IDLE to cancel, that is simply no accept.
- hrdata is 0 whenever not in a read DATA cycle.
- Back-to-back write then read of the same address returns the new data: the write commits before the read's DATA cycle.
- hready is ignored while this slave is stalling (WAIT/ERR1); the slave's own state drives the bus.
- Latency: an OKAY transfer occupies WAIT_STATES+1 data-phase cycles; an ERROR transfer occupies exactly 2.

Optional Feature:
- Macro: AHB_SLV_ERR_RESP_EN.
- Defined: error checking and the ERR1/ERR2 response as specified above.
- Undefined:
  - No error detection; hresp tied 00.
  - Upper address bits are ignored, so the address wraps modulo the memory size.
  - Misaligned accesses use haddr aligned down to the transfer size.
  - hsize>2 is treated as word.
  - ERR states are absent.

Test Plan:
- Reset, WAIT_STATES=1: NONSEQ word write 0xDEADBEEF to 0x08, then read 0x08 -> write data phase shows 1 cycle hreadyout=0 then 1; read returns 0xDEADBEEF with hresp=00.
- Byte write 0xAA to 0x05 and halfword write 0x1234 to 0x0E over a zeroed memory -> word read 0x04 = 0x0000AA00; word read 0x0C = 0x12340000.
- WAIT_STATES=0: pipelined write 0x11 to 0x00 then read 0x00 on consecutive cycles -> hreadyout stays 1 throughout; read returns 0x00000011.
- With AHB_SLV_ERR_RESP_EN, ADDR_W=4: read 0x40 and misaligned word at 0x02 -> each gives hreadyout 0 then 1 with hresp=01 both cycles; memory unchanged.
- htrans=BUSY, or hsel=0 with NONSEQ -> no data phase; hreadyout=1, hresp=00, memory unchanged.
- Assert hreset during the WAIT of a write to 0x04 -> outputs return to reset values immediately; a subsequent read of 0x04 returns 0.
